snapshot_ctrl: RTL and testbench
================================

// Module: snapshot_ctrl
// PURPOSE
//  Sequencer for the BERT snapshot shift register (PWidth-bit, SWidth bits/shift).
//  Arms on request, waits for a trigger edge, drives the shift enable for exactly
//  PWidth/SWidth cycles to fill the register, then holds the data until software acks.
//  Sits between the register/control interface and the snapshot shift register's en input.
// PARAMETERS
//  PWidth    32  snapshot register width; must be an integer multiple of SWidth
//  SWidth    1   bits shifted in per enabled cycle
//  DlyWidth  16  width of trigger-delay count (used only with SNAPSHOT_TRIG_DELAY_EN)
// PORTS
//  clk          in   1         clock
//  reset        in   1         asynchronous, active-high reset
//  arm          in   1         1-cycle pulse: start a capture; honoured only in IDLE
//  abort        in   1         force return to IDLE from any state; wins over all inputs
//  trig         in   1         trigger level, synchronous to clk; rising edge fires capture
//  rd_ack       in   1         1-cycle pulse: snapshot consumed; honoured only in HOLD
//  trig_dly     in   DlyWidth  cycles between trigger edge and first shift (macro only)
//  shift_en     out  1         enable to snapshot shift register
//  busy         out  1         high in ARMED/DELAY/CAPTURE
//  done         out  1         high in HOLD: register contents stable and valid
//  missed_trig  out  1         sticky: trigger edge seen in CAPTURE or HOLD
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, trig_q=0, shift_en=0, busy=0, done=0, missed_trig=0.
//  - NShift = PWidth/SWidth; cnt width CntW = clog2(NShift), min 1.
//  - trig_q <= trig every cycle in every state; edge = trig & ~trig_q. A trig held high
//    before arm does not fire; a fresh rising edge is required.
//  - IDLE: arm -> ARMED; missed_trig cleared on arm. rd_ack ignored.
//  - ARMED: edge -> CAPTURE (or DELAY, see CONFIGURATION). arm ignored.
//  - CAPTURE: shift_en=1 (registered output); cnt increments each cycle; at
//    cnt==NShift-1 -> HOLD and cnt<=0. Exactly NShift shift_en cycles, no gaps.
//  - HOLD: done=1, shift_en=0. rd_ack -> IDLE; rd_ack and arm same cycle -> ARMED.
//  - Latency: edge sampled at cycle t -> shift_en high t+1..t+NShift, done high from t+NShift+1.
//  - Edge in CAPTURE or HOLD sets missed_trig; it does not restart or extend capture.
//  - abort: next state IDLE, shift_en=0, cnt=0, done=0 next cycle; missed_trig kept.
//    abort with arm same cycle -> IDLE (abort wins). Partial data left in register.
//  - Outputs are registered and decoded from state; no combinational path from inputs.
// CONFIGURATION
//  SNAPSHOT_TRIG_DELAY_EN defined: extra DELAY state. On edge in ARMED, dly_cnt<=trig_dly;
//    trig_dly==0 -> straight to CAPTURE (same latency as without macro). Otherwise stay in
//    DELAY for trig_dly cycles, then CAPTURE; shift_en first high at t+trig_dly+1.
//    trig_dly is sampled only on the edge. busy=1 in DELAY; edges in DELAY are ignored
//    (no missed_trig). abort in DELAY -> IDLE.
//  Not defined: no DELAY state or dly_cnt; trig_dly port present but unused.
// STRUCTURE
//  - Package snapshot_ctrl_pkg: state encoding constants (IDLE, ARMED, DELAY, CAPTURE,
//    HOLD; 3-bit), clog2 function.
//  - One sub-module: snapshot_ctrl_cnt, a loadable down/up counter with terminal flag,
//    used for the capture count and (macro) the delay count. FSM stays in snapshot_ctrl.
// TESTING
//  1 PWidth=32,SWidth=1: arm, trig rise at t -> shift_en high exactly 32 cycles t+1..t+32; done at t+33
//  2 trig high before arm, kept high -> no capture; drop then raise -> capture starts next cycle
//  3 PWidth=32,SWidth=4: full capture -> exactly 8 shift_en cycles; second trig edge mid-capture
//    -> missed_trig=1, shift_en count still 8; cleared by next arm
//  4 abort at capture cycle 5 -> shift_en low next cycle, busy=0, done=0; later arm+trig -> full 32-cycle run
//  5 HOLD: rd_ack+arm same cycle -> ARMED, done=0 next cycle; arm alone in HOLD -> ignored, done stays 1
//  6 macro on: trig_dly=10 -> first shift_en at t+11, done at t+43; trig_dly=0 -> same timing as scenario 1

Source files
------------

// File: rtl/snapshot_ctrl_pkg.sv
// Shared definitions for the BERT snapshot sequencer: FSM state encoding and a
// width helper.
package snapshot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/snapshot_ctrl_cnt.sv
// Loadable up/down counter with a terminal-value flag; serves as the capture
// length counter and the trigger-delay counter of snapshot_ctrl.
module snapshot_ctrl_cnt
  import snapshot_ctrl_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  input  logic             down,
  input  logic [Width-1:0] term_val,
  output logic             term
);

  localparam logic [Width-1:0] CntOne  = Width'(1'b1);
  localparam logic [Width-1:0] CntZero = Width'(1'b0);

  logic [Width-1:0] cnt_r;

  // Count register: clear beats load, load beats stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CntZero;
    end else if (clr) begin
      cnt_r <= CntZero;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      cnt_r <= down ? (cnt_r - CntOne) : (cnt_r + CntOne);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = (cnt_r == term_val);

endmodule

// File: rtl/snapshot_ctrl.sv
// Snapshot shift-register sequencer: arm, wait for trigger edge, shift PWidth/SWidth
// cycles, hold until acked. Optional trigger delay enabled by SNAPSHOT_TRIG_DELAY_EN.
module snapshot_ctrl
  import snapshot_ctrl_pkg::*;
#(
  parameter int PWidth   = 32,
  parameter int SWidth   = 1,
  parameter int DlyWidth = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig,
  input  logic                rd_ack,
  input  logic [DlyWidth-1:0] trig_dly,
  output logic                shift_en,
  output logic                busy,
  output logic                done,
  output logic                missed_trig
);

  localparam int NShift = PWidth / SWidth;
  localparam int CntW   = clog2(NShift);
  localparam logic [CntW-1:0] CapLast = CntW'(NShift - 1);
  localparam logic [CntW-1:0] CapZero = CntW'(1'b0);

  state_e state_r;
  logic   trig_q_r;
  logic   shift_en_r;
  logic   busy_r;
  logic   done_r;
  logic   missed_r;
  logic   edge_s;
  logic   cap_clr_s;
  logic   cap_en_s;
  logic   cap_term_s;

  assign edge_s    = trig & ~trig_q_r;
  assign cap_en_s  = (state_r == ST_CAPTURE);
  assign cap_clr_s = abort | (cap_en_s & cap_term_s);

  snapshot_ctrl_cnt #(.Width(CntW)) u_cap_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cap_clr_s),
    .load     (1'b0),
    .load_val (CapZero),
    .en       (cap_en_s),
    .down     (1'b0),
    .term_val (CapLast),
    .term     (cap_term_s)
  );

`ifdef SNAPSHOT_TRIG_DELAY_EN
  logic dly_load_s;
  logic dly_en_s;
  logic dly_term_s;

  // The delay count is only captured on the firing edge; it counts down to 1.
  assign dly_load_s = (state_r == ST_ARMED) & edge_s & ~abort;
  assign dly_en_s   = (state_r == ST_DELAY);

  snapshot_ctrl_cnt #(.Width(DlyWidth)) u_dly_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (abort),
    .load     (dly_load_s),
    .load_val (trig_dly),
    .en       (dly_en_s),
    .down     (1'b1),
    .term_val (DlyWidth'(1'b1)),
    .term     (dly_term_s)
  );
`else
  logic unused_trig_dly_s;
  assign unused_trig_dly_s = ^trig_dly;
`endif

  // Sequencer FSM with registered, state-decoded outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      trig_q_r   <= 1'b0;
      shift_en_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      missed_r   <= 1'b0;
    end else begin
      trig_q_r <= trig;
      if (abort) begin
        state_r    <= ST_IDLE;
        shift_en_r <= 1'b0;
        busy_r     <= 1'b0;
        done_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (arm) begin
              state_r  <= ST_ARMED;
              busy_r   <= 1'b1;
              missed_r <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (edge_s) begin
`ifdef SNAPSHOT_TRIG_DELAY_EN
              if (trig_dly != {DlyWidth{1'b0}}) begin
                state_r <= ST_DELAY;
              end else begin
                state_r    <= ST_CAPTURE;
                shift_en_r <= 1'b1;
              end
`else
              state_r    <= ST_CAPTURE;
              shift_en_r <= 1'b1;
`endif
            end
          end
          ST_DELAY: begin
`ifdef SNAPSHOT_TRIG_DELAY_EN
            if (dly_term_s) begin
              state_r    <= ST_CAPTURE;
              shift_en_r <= 1'b1;
            end
`else
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
`endif
          end
          ST_CAPTURE: begin
            if (edge_s) begin
              missed_r <= 1'b1;
            end
            if (cap_term_s) begin
              state_r    <= ST_HOLD;
              shift_en_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (edge_s) begin
              missed_r <= 1'b1;
            end
            if (rd_ack) begin
              done_r <= 1'b0;
              if (arm) begin
                state_r <= ST_ARMED;
                busy_r  <= 1'b1;
              end else begin
                state_r <= ST_IDLE;
              end
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            shift_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign shift_en    = shift_en_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign missed_trig = missed_r;

endmodule

// File: tb/tb_snapshot_ctrl.sv
// Directed bench for snapshot_ctrl: one instance with SWidth=1, one with SWidth=4.
module tb_snapshot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic        trig;
  logic        rd_ack;
  logic [15:0] trig_dly;
  logic        shift_en1, busy1, done1, missed1;
  logic        shift_en4, busy4, done4, missed4;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  snapshot_ctrl #(.PWidth(32), .SWidth(1), .DlyWidth(16)) dut1 (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig(trig),
    .rd_ack(rd_ack), .trig_dly(trig_dly), .shift_en(shift_en1),
    .busy(busy1), .done(done1), .missed_trig(missed1)
  );

  snapshot_ctrl #(.PWidth(32), .SWidth(4), .DlyWidth(16)) dut4 (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig(trig),
    .rd_ack(rd_ack), .trig_dly(trig_dly), .shift_en(shift_en4),
    .busy(busy4), .done(done4), .missed_trig(missed4)
  );

  task automatic do_reset();
    trig = 1'b0; arm = 1'b0; abort = 1'b0; rd_ack = 1'b0; trig_dly = 16'd0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Samples at negedges 1..ncyc; index k means k clock edges after the current negedge.
  task automatic measure(input int ncyc, input bit use4, output int first_en,
                         output int last_en, output int n_en, output int first_done);
    logic se, dn;
    first_en = 0; last_en = 0; n_en = 0; first_done = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      se = use4 ? shift_en4 : shift_en1;
      dn = use4 ? done4 : done1;
      if (se) begin
        n_en++;
        if (first_en == 0) first_en = k;
        last_en = k;
      end
      if (dn && first_done == 0) first_done = k;
    end
  endtask

  task automatic test_reset();
    trig = 1'b0; arm = 1'b0; abort = 1'b0; rd_ack = 1'b0; trig_dly = 16'd0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({shift_en1, busy1, done1, missed1} !== 4'b0000) begin
      failures++; $display("FAIL reset_dut1 actual=%b expected=0000", {shift_en1, busy1, done1, missed1});
    end
    checks++;
    if ({shift_en4, busy4, done4, missed4} !== 4'b0000) begin
      failures++; $display("FAIL reset_dut4 actual=%b expected=0000", {shift_en4, busy4, done4, missed4});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int fe, le, ne, fd;
    do_reset();
    pulse_arm();
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL basic_busy_armed actual=%b expected=1", busy1); end
    trig = 1'b1;
    measure(40, 1'b0, fe, le, ne, fd);
    checks++;
    if (fe !== 1) begin failures++; $display("FAIL basic_first_en actual=%0d expected=1", fe); end
    checks++;
    if (le !== 32) begin failures++; $display("FAIL basic_last_en actual=%0d expected=32", le); end
    checks++;
    if (ne !== 32) begin failures++; $display("FAIL basic_num_en actual=%0d expected=32", ne); end
    checks++;
    if (fd !== 33) begin failures++; $display("FAIL basic_first_done actual=%0d expected=33", fd); end
    checks++;
    if ({busy1, done1} !== 2'b01) begin failures++; $display("FAIL basic_hold actual=%b expected=01", {busy1, done1}); end
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    checks++;
    if (done1 !== 1'b0) begin failures++; $display("FAIL basic_ack_done actual=%b expected=0", done1); end
  endtask

  task automatic test_held_trig();
    int fe, le, ne, fd;
    do_reset();
    trig = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pulse_arm();
    repeat (4) @(negedge clk);
    checks++;
    if ({shift_en1, busy1} !== 2'b01) begin failures++; $display("FAIL held_no_fire actual=%b expected=01", {shift_en1, busy1}); end
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    measure(34, 1'b0, fe, le, ne, fd);
    checks++;
    if (fe !== 1) begin failures++; $display("FAIL held_first_en actual=%0d expected=1", fe); end
    checks++;
    if (ne !== 32) begin failures++; $display("FAIL held_num_en actual=%0d expected=32", ne); end
  endtask

  task automatic test_swidth4_missed();
    int fe = 0, le = 0, ne = 0, fd = 0;
    do_reset();
    pulse_arm();
    trig = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (shift_en4) begin
        ne++;
        if (fe == 0) fe = k;
        le = k;
      end
      if (done4 && fd == 0) fd = k;
      if (k == 3) trig = 1'b0;
      if (k == 4) trig = 1'b1;
    end
    checks++;
    if (fe !== 1) begin failures++; $display("FAIL sw4_first_en actual=%0d expected=1", fe); end
    checks++;
    if (ne !== 8 || le !== 8) begin failures++; $display("FAIL sw4_num_en actual=%0d/%0d expected=8/8", ne, le); end
    checks++;
    if (fd !== 9) begin failures++; $display("FAIL sw4_first_done actual=%0d expected=9", fd); end
    checks++;
    if (missed4 !== 1'b1) begin failures++; $display("FAIL sw4_missed_set actual=%b expected=1", missed4); end
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    checks++;
    if ({done4, missed4} !== 2'b01) begin failures++; $display("FAIL sw4_missed_sticky actual=%b expected=01", {done4, missed4}); end
    pulse_arm();
    checks++;
    if ({busy4, missed4} !== 2'b10) begin failures++; $display("FAIL sw4_missed_clear actual=%b expected=10", {busy4, missed4}); end
  endtask

  task automatic test_abort();
    int fe, le, ne, fd;
    do_reset();
    pulse_arm();
    trig = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (shift_en1 !== 1'b1) begin failures++; $display("FAIL abort_pre_en actual=%b expected=1", shift_en1); end
    abort = 1'b1;
    arm = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    arm = 1'b0;
    checks++;
    if ({shift_en1, busy1, done1} !== 3'b000) begin
      failures++; $display("FAIL abort_outputs actual=%b expected=000", {shift_en1, busy1, done1});
    end
    trig = 1'b0;
    pulse_arm();
    trig = 1'b1;
    measure(36, 1'b0, fe, le, ne, fd);
    checks++;
    if (fe !== 1 || ne !== 32) begin failures++; $display("FAIL abort_rerun actual=%0d/%0d expected=1/32", fe, ne); end
    checks++;
    if (fd !== 33) begin failures++; $display("FAIL abort_rerun_done actual=%0d expected=33", fd); end
  endtask

  task automatic test_hold_ack_arm();
    int fe, le, ne, fd;
    do_reset();
    pulse_arm();
    trig = 1'b1;
    measure(36, 1'b0, fe, le, ne, fd);
    trig = 1'b0;
    pulse_arm();
    checks++;
    if ({busy1, done1} !== 2'b01) begin failures++; $display("FAIL hold_arm_ignored actual=%b expected=01", {busy1, done1}); end
    arm = 1'b1;
    rd_ack = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    rd_ack = 1'b0;
    checks++;
    if ({busy1, done1} !== 2'b10) begin failures++; $display("FAIL hold_ack_arm actual=%b expected=10", {busy1, done1}); end
    trig = 1'b1;
    @(negedge clk);
    checks++;
    if (shift_en1 !== 1'b1) begin failures++; $display("FAIL hold_rearmed_fire actual=%b expected=1", shift_en1); end
  endtask

`ifdef SNAPSHOT_TRIG_DELAY_EN
  task automatic test_delay();
    int fe, le, ne, fd;
    do_reset();
    trig_dly = 16'd10;
    pulse_arm();
    trig = 1'b1;
    measure(50, 1'b0, fe, le, ne, fd);
    checks++;
    if (fe !== 11 || ne !== 32) begin failures++; $display("FAIL dly10_en actual=%0d/%0d expected=11/32", fe, ne); end
    checks++;
    if (fd !== 43) begin failures++; $display("FAIL dly10_done actual=%0d expected=43", fd); end
    do_reset();
    trig_dly = 16'd0;
    pulse_arm();
    trig = 1'b1;
    measure(40, 1'b0, fe, le, ne, fd);
    checks++;
    if (fe !== 1 || ne !== 32 || fd !== 33) begin
      failures++; $display("FAIL dly0_timing actual=%0d/%0d/%0d expected=1/32/33", fe, ne, fd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_held_trig();
    test_swidth4_missed();
    test_abort();
    test_hold_ack_arm();
`ifdef SNAPSHOT_TRIG_DELAY_EN
    test_delay();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
